// File: rtl/seq_mult4.sv
// seq_mult4: sequential 4x4 unsigned shift-and-add multiplier sharing one
// 4-bit ripple-carry adder built from four fulladder cells.
// Latency: start accepted at E0, result and done pulse after E4, next accept at E6.
// Backpressure: none; start is only sampled in IDLE and is dropped otherwise.
//
// Ports:
//   clock   in   system clock, rising edge
//   resetn  in   asynchronous active-low reset
//   start   in   operation request, sampled only in IDLE
//   a       in   [3:0] multiplicand, captured on accepted start
//   b       in   [3:0] multiplier, captured on accepted start
//   product out  [7:0] result register (intermediate values visible during RUN)
//   busy    out  high while the four add/shift steps are running
//   done    out  one-cycle pulse when product holds the final result

// fulladder: one-bit full adder cell.
// Latency: combinational.
// Backpressure: none.
module fulladder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// ripple_add4: 4-bit ripple-carry adder chained from fulladder cells.
// Latency: combinational.
// Backpressure: none.
module ripple_add4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    fulladder u_fa (
      .x    (x[i]),
      .y    (y[i]),
      .cin  (carry[i]),
      .s    (s[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[4];

endmodule

// seq_mult4: controller and register file around the shared adder.
// Latency: 4 cycles start-to-done, issue interval 6 cycles.
// Backpressure: start ignored (not queued) in RUN and DONE.
module seq_mult4 (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] mcand;
  logic [7:0] p;
  logic [1:0] cnt;
  logic       busy_q;
  logic       done_q;

  logic [3:0] hi;
  logic [3:0] lo;
  logic [3:0] sum;
  logic       carry;

  assign hi = p[7:4];
  assign lo = p[3:0];

  // The single adder: always hi + mcand; the step logic decides whether
  // its result is used or hi passes through unchanged.
  ripple_add4 u_add (
    .x    (hi),
    .y    (mcand),
    .cin  (1'b0),
    .s    (sum),
    .cout (carry)
  );

  // busy/done are kept as registers that track state so the outputs come
  // straight from flops rather than from a state decode.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      mcand  <= 4'd0;
      p      <= 8'd0;
      cnt    <= 2'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            p      <= {4'b0000, b};
            cnt    <= 2'd0;
            state  <= RUN;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end

        RUN: begin
          // The upper half accumulates the partial sum; the lower half
          // shifts the multiplier out as the product bits shift in.
          if (lo[0]) begin
            p <= {carry, sum, lo[3:1]};
          end else begin
            p <= {1'b0, hi, lo[3:1]};
          end
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign product = p;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_mult4.sv
// tb_seq_mult4: directed self-checking bench for seq_mult4.
// Ports: none (top-level bench); drives clock, resetn, start, a, b.
module tb_seq_mult4;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] product;
  logic       busy;
  logic       done;

  int n_checks;
  int n_fail;

  seq_mult4 dut (
    .clock   (clock),
    .resetn  (resetn),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full operation from IDLE; checks the busy window, done pulse and result.
  task automatic run_op(input logic [3:0] ai, input logic [3:0] bi,
                        input logic [7:0] exp, input string tag);
    a     = ai;
    b     = bi;
    start = 1'b1;
    tick();                       // E0: accepted
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
      chk({tag, "_nodone"}, {7'd0, done}, 8'd0);
      tick();                     // E1..E4
    end
    chk({tag, "_busy_fall"}, {7'd0, busy}, 8'd0);
    chk({tag, "_done"}, {7'd0, done}, 8'd1);
    chk({tag, "_product"}, product, exp);
    tick();                       // E5: back to IDLE
    chk({tag, "_done_fall"}, {7'd0, done}, 8'd0);
    chk({tag, "_hold"}, product, exp);
  endtask

  int d0, d1, d2, nd;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    start    = 1'b0;
    a        = 4'd0;
    b        = 4'd0;

    // Reset values appear before any clock edge.
    #2;
    chk("rst_product", product, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_product", product, 8'd0);
      chk("idle_busy", {7'd0, busy}, 8'd0);
      chk("idle_done", {7'd0, done}, 8'd0);
    end

    // Basic multiply 7 x 9 = 63, then hold for 20 idle cycles.
    run_op(4'd7, 4'd9, 8'h3F, "mul_7x9");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_63", product, 8'h3F);
      chk("hold_busy", {7'd0, busy}, 8'd0);
      chk("hold_done", {7'd0, done}, 8'd0);
    end

    // Corners.
    run_op(4'd15, 4'd15, 8'hE1, "mul_15x15");
    run_op(4'd0, 4'd13, 8'h00, "mul_0x13");
    run_op(4'd11, 4'd0, 8'h00, "mul_11x0");
    run_op(4'd1, 4'd1, 8'h01, "mul_1x1");

    // Exhaustive sweep against the bench's own arithmetic.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(4'(i), 4'(j), 8'(i * j), "sweep");
      end
    end

    // Start pulses during RUN and DONE are ignored.
    a = 4'd3; b = 4'd5; start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    tick();                       // E1
    a = 4'd15; b = 4'd15; start = 1'b1;
    tick();                       // E2
    start = 1'b0;
    tick();                       // E3
    tick();                       // E4: DONE
    chk("ign_done", {7'd0, done}, 8'd1);
    chk("ign_product", product, 8'd15);
    start = 1'b1;
    tick();                       // E5: start seen in DONE, ignored
    start = 1'b0;
    chk("ign_done_fall", {7'd0, done}, 8'd0);
    chk("ign_busy", {7'd0, busy}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ign_no_second_busy", {7'd0, busy}, 8'd0);
      chk("ign_no_second_done", {7'd0, done}, 8'd0);
      chk("ign_product_hold", product, 8'd15);
    end

    // Continuous start: done every 6 cycles, each with 12.
    a = 4'd2; b = 4'd6; start = 1'b1;
    d0 = 0; d1 = 0; d2 = 0; nd = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done === 1'b1) begin
        chk("cont_product", product, 8'd12);
        if (nd == 0) d0 = c;
        else if (nd == 1) d1 = c;
        else if (nd == 2) d2 = c;
        nd++;
      end
    end
    start = 1'b0;
    chk("cont_pulses", 8'(nd), 8'd3);
    chk("cont_first", 8'(d0), 8'd5);
    chk("cont_gap1", 8'(d1 - d0), 8'd6);
    chk("cont_gap2", 8'(d2 - d1), 8'd6);
    for (int i = 0; i < 6; i++) tick();
    chk("cont_drained_busy", {7'd0, busy}, 8'd0);
    chk("cont_drained_product", product, 8'd12);

    // Reset during RUN aborts the operation at once.
    a = 4'd9; b = 4'd9; start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    tick();                       // E1
    tick();                       // E2
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_product", product, 8'd0);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_done", {7'd0, done}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_held_busy", {7'd0, busy}, 8'd0);
      chk("abort_held_product", product, 8'd0);
    end
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_done", {7'd0, done}, 8'd0);
      chk("abort_no_busy", {7'd0, busy}, 8'd0);
    end
    run_op(4'd4, 4'd4, 8'd16, "mul_4x4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
